// File: rtl/muldiv_issue_ctrl.sv
// Issue/scoreboard/write-back arbiter for a shared multi-cycle MUL/DIV unit beside EXE.
// Define MD_PERF_CNT_EN to add the perf_md_ops / perf_md_stall counters.
module muldiv_issue_ctrl #(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            md_op_ID,
    input  logic            rs1use_ID,
    input  logic            rs2use_ID,
    input  logic            RegWrite_ID,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    input  logic [4:0]      rd_ID,
    input  logic            md_issue_EXE,
    input  logic [4:0]      rd_EXE,
    input  logic            flush_EXE,
    input  logic            RegWrite_WB,
    input  logic [4:0]      rd_WB,
    input  logic            md_done,
    input  logic [XLEN-1:0] md_result,
    output logic            md_start,
    output logic            stall_ID,
    output logic            force_wb,
    output logic            md_wb_en,
    output logic [4:0]      md_wb_rd,
    output logic [XLEN-1:0] md_wb_data,
`ifdef MD_PERF_CNT_EN
    output logic [31:0]     perf_md_ops,
    output logic [31:0]     perf_md_stall,
`endif
    output logic            md_busy
);
    typedef enum logic [1:0] {IDLE, BUSY, WAIT_WB} state_t;

    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    state_t            state, state_nxt;
    logic              pend_valid;
    logic [4:0]        pend_rd;
    logic [XLEN-1:0]   result_q;
    logic [CW-1:0]     starve_cnt;
    logic              issue, slot_free, grant, start_c;
    logic              raw, waw, structural;

    assign issue     = md_issue_EXE && !flush_EXE;
    assign slot_free = !RegWrite_WB || (rd_WB == 5'd0);
    assign grant     = (state == WAIT_WB) && (slot_free || (starve_cnt == LIM));

    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        case (state)
            IDLE: if (issue) begin
                start_c   = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (md_done) state_nxt = WAIT_WB;
            WAIT_WB: if (grant) begin
                if (issue) begin
                    start_c   = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign md_start   = start_c && rst_n;
    assign md_busy    = (state != IDLE);
    assign md_wb_en   = grant && (pend_rd != 5'd0);
    assign md_wb_rd   = md_wb_en ? pend_rd : 5'd0;
    assign md_wb_data = md_wb_en ? result_q : '0;
    assign force_wb   = grant && !slot_free;

    assign raw = pend_valid && (state != IDLE) &&
                 ((rs1use_ID && rs1_ID == pend_rd) || (rs2use_ID && rs2_ID == pend_rd));
    assign waw = pend_valid && RegWrite_ID && (rd_ID == pend_rd) && (rd_ID != 5'd0);
    // The unit is considered free in its grant cycle so a waiting MD op in ID can advance.
    assign structural = md_op_ID && (((state != IDLE) && !grant) || issue);
    // Write-first register file: ID already sees the value in the md_wb_en cycle.
    assign stall_ID = rst_n && (((raw || waw) && !md_wb_en) || structural);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            pend_rd    <= 5'd0;
            result_q   <= '0;
            starve_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (start_c) begin
                pend_rd    <= rd_EXE;
                pend_valid <= (rd_EXE != 5'd0);
            end else if (grant) begin
                pend_valid <= 1'b0;
            end
            if (state == BUSY && md_done) begin
                result_q   <= md_result;
                starve_cnt <= '0;
            end else if (state == WAIT_WB && !grant && starve_cnt != LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

`ifdef MD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_md_ops   <= 32'd0;
            perf_md_stall <= 32'd0;
        end else begin
            if (md_start)             perf_md_ops   <= perf_md_ops + 32'd1;
            if (stall_ID || force_wb) perf_md_stall <= perf_md_stall + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_muldiv_issue_ctrl.sv
// Directed bench for muldiv_issue_ctrl: issue, scoreboard stalls, starvation steal, reset.
module tb_muldiv_issue_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        md_op_ID, rs1use_ID, rs2use_ID, RegWrite_ID;
    logic [4:0]  rs1_ID, rs2_ID, rd_ID, rd_EXE, rd_WB;
    logic        md_issue_EXE, flush_EXE, RegWrite_WB, md_done;
    logic [31:0] md_result;
    logic        md_start, stall_ID, force_wb, md_wb_en, md_busy;
    logic [4:0]  md_wb_rd;
    logic [31:0] md_wb_data;

    int n_chk = 0;
    int n_fail = 0;
    int busy_n;

    muldiv_issue_ctrl #(.STARVE_LIMIT(4), .XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .md_op_ID(md_op_ID), .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
        .RegWrite_ID(RegWrite_ID), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
        .md_issue_EXE(md_issue_EXE), .rd_EXE(rd_EXE), .flush_EXE(flush_EXE),
        .RegWrite_WB(RegWrite_WB), .rd_WB(rd_WB),
        .md_done(md_done), .md_result(md_result),
        .md_start(md_start), .stall_ID(stall_ID), .force_wb(force_wb),
        .md_wb_en(md_wb_en), .md_wb_rd(md_wb_rd), .md_wb_data(md_wb_data),
        .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        md_op_ID = 0; rs1use_ID = 0; rs2use_ID = 0; RegWrite_ID = 0;
        rs1_ID = 0; rs2_ID = 0; rd_ID = 0; rd_EXE = 0; rd_WB = 0;
        md_issue_EXE = 0; flush_EXE = 0; RegWrite_WB = 0; md_done = 0; md_result = 0;
    endtask

    initial begin
        idle_in();
        rst_n = 0;
        md_issue_EXE = 1; md_op_ID = 1;
        cyc(); cyc();
        chk("rst_start", md_start, 0);
        chk("rst_stall", stall_ID, 0);
        chk("rst_force", force_wb, 0);
        chk("rst_wb_en", md_wb_en, 0);
        chk("rst_wb_rd", md_wb_rd, 0);
        chk("rst_wb_data", md_wb_data, 0);
        chk("rst_busy", md_busy, 0);
        idle_in();
        rst_n = 1;

        // basic issue, 8-cycle unit, RAW on rs1
        cyc();
        md_issue_EXE = 1; rd_EXE = 5; #1;
        chk("t1_start", md_start, 1);
        chk("t1_busy0", md_busy, 0);
        busy_n = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            md_issue_EXE = 0; rs1use_ID = 1; rs1_ID = 5;
            md_done = (k == 8); md_result = 32'hdeadbeef; #1;
            chk("t1_nostart", md_start, 0);
            chk("t1_raw", stall_ID, 1);
            if (md_busy) busy_n++;
        end
        cyc();
        md_done = 0; #1;
        chk("t1_wb_en", md_wb_en, 1);
        chk("t1_wb_rd", md_wb_rd, 5);
        chk("t1_wb_data", md_wb_data, 32'hdeadbeef);
        chk("t1_raw_release", stall_ID, 0);
        chk("t1_force", force_wb, 0);
        if (md_busy) busy_n++;
        cyc(); #1;
        chk("t1_idle", md_busy, 0);
        chk("t1_wb_off", md_wb_en, 0);
        chk("t1_busy_cycles", busy_n, 9);
        chk("t1_idle_nostall", stall_ID, 0);

        // back-to-back: structural, WAW, release at grant, start with write
        idle_in();
        md_issue_EXE = 1; rd_EXE = 9; #1;
        chk("t2_start", md_start, 1);
        cyc();
        md_issue_EXE = 0; md_op_ID = 1; #1;
        chk("t2_struct", stall_ID, 1);
        chk("t2_nostart", md_start, 0);
        cyc();
        md_op_ID = 0; RegWrite_ID = 1; rd_ID = 9; md_done = 1; md_result = 32'h12345678; #1;
        chk("t2_waw", stall_ID, 1);
        cyc();
        md_done = 0; RegWrite_ID = 0; md_op_ID = 1; #1;
        chk("t2_wb_en", md_wb_en, 1);
        chk("t2_wb_rd", md_wb_rd, 9);
        chk("t2_release", stall_ID, 0);
        cyc();
        md_op_ID = 0; md_issue_EXE = 1; rd_EXE = 12; #1;
        chk("t2_start2", md_start, 1);
        cyc();
        md_issue_EXE = 0; md_done = 1; md_result = 32'h000000aa; #1;
        cyc();
        md_done = 0; md_issue_EXE = 1; rd_EXE = 14; #1;
        chk("t2_start_with_wb", md_start, 1);
        chk("t2_wb_en2", md_wb_en, 1);
        chk("t2_wb_rd2", md_wb_rd, 12);
        chk("t2_wb_data2", md_wb_data, 32'haa);
        cyc();
        md_issue_EXE = 0; rs2use_ID = 1; rs2_ID = 14; #1;
        chk("t2_busy_again", md_busy, 1);
        chk("t2_nostart_busy", md_start, 0);
        chk("t2_raw_rs2", stall_ID, 1);
        cyc();
        rs2use_ID = 0; md_done = 1; md_result = 32'h1; #1;
        cyc();
        md_done = 0; #1;
        chk("t2_wb_rd3", md_wb_rd, 14);
        cyc();

        // starvation: WB port busy with rd 7 -> 4 waits then forced steal
        idle_in();
        md_issue_EXE = 1; rd_EXE = 3; #1;
        cyc();
        md_issue_EXE = 0; md_done = 1; md_result = 32'h33; #1;
        cyc();
        md_done = 0; RegWrite_WB = 1; rd_WB = 7; #1;
        chk("t3_wait0", md_wb_en, 0);
        for (int k = 1; k <= 3; k++) begin
            cyc(); #1;
            chk("t3_wait", md_wb_en, 0);
            chk("t3_noforce", force_wb, 0);
        end
        cyc(); #1;
        chk("t3_steal_en", md_wb_en, 1);
        chk("t3_force", force_wb, 1);
        chk("t3_steal_rd", md_wb_rd, 3);
        chk("t3_steal_data", md_wb_data, 32'h33);
        cyc(); #1;
        chk("t3_force_once", force_wb, 0);
        chk("t3_idle", md_busy, 0);

        // WB writing x0 leaves the slot free
        idle_in();
        RegWrite_WB = 1; rd_WB = 0; md_issue_EXE = 1; rd_EXE = 4; #1;
        cyc();
        md_issue_EXE = 0; md_done = 1; md_result = 32'h44; #1;
        cyc();
        md_done = 0; #1;
        chk("t3b_wb_en", md_wb_en, 1);
        chk("t3b_noforce", force_wb, 0);
        cyc();

        // rd=0 op: no scoreboard, no write
        idle_in();
        md_issue_EXE = 1; rd_EXE = 0; #1;
        chk("t4_start", md_start, 1);
        cyc();
        md_issue_EXE = 0; rs1use_ID = 1; rs1_ID = 0; md_done = 1; md_result = 32'h55; #1;
        chk("t4_noraw", stall_ID, 0);
        chk("t4_busy", md_busy, 1);
        cyc();
        md_done = 0; #1;
        chk("t4_no_wb", md_wb_en, 0);
        chk("t4_busy_wait", md_busy, 1);
        cyc(); #1;
        chk("t4_idle", md_busy, 0);

        // flushed EXE slot does not issue
        idle_in();
        md_issue_EXE = 1; flush_EXE = 1; rd_EXE = 8; #1;
        chk("t5_nostart", md_start, 0);
        cyc();
        idle_in(); #1;
        chk("t5_idle", md_busy, 0);

        // async reset mid-BUSY, stale md_done ignored
        md_issue_EXE = 1; rd_EXE = 6; #1;
        cyc();
        md_issue_EXE = 0; #1;
        chk("t6_busy", md_busy, 1);
        md_op_ID = 1; rst_n = 0; #1;
        chk("t6_rst_busy", md_busy, 0);
        chk("t6_rst_stall", stall_ID, 0);
        chk("t6_rst_start", md_start, 0);
        cyc();
        md_op_ID = 0; rst_n = 1; md_done = 1; md_result = 32'h66; #1;
        cyc();
        md_done = 0; #1;
        chk("t6_stale_wb", md_wb_en, 0);
        chk("t6_stale_busy", md_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
